// File: rtl/multi_ff_pkg.sv
// Shared definitions for the multi-channel gated flop reduction block.
package multi_ff_pkg;

    localparam int unsigned MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_AND   = 2'b00;
    localparam logic [MODE_W-1:0] MODE_OR    = 2'b01;
    localparam logic [MODE_W-1:0] MODE_XOR   = 2'b10;
    localparam logic [MODE_W-1:0] MODE_PASS0 = 2'b11;

endpackage

// File: rtl/ff_chain.sv
// DEPTH-stage register chain: stage 0 loads d when load=1 (else holds),
// later stages shift; the whole chain advances only when en=1.
module ff_chain #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;
    logic [DEPTH-1:0][WIDTH-1:0] stage_d;

    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = load ? d : stage_q[0];
        for (int k = 1; k < int'(DEPTH); k++) begin
            stage_d[k] = stage_q[k-1];
        end
    end

    // Reset wins over en; en=0 freezes every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else if (en) begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/multi_ff_reduce.sv
// N gated register chains merged by a runtime-selectable bitwise reduction
// into one registered, valid-qualified result.
module multi_ff_reduce
    import multi_ff_pkg::*;
#(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned DEPTH    = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [CHANNELS-1:0]       ch_en,
    input  logic [CHANNELS*WIDTH-1:0] d,
    input  logic                      in_valid,
    input  logic [MODE_W-1:0]         mode,
    output logic [CHANNELS*WIDTH-1:0] ch_q,
    output logic [WIDTH-1:0]          q,
    output logic                      q_valid
);

    logic             v_last;
    logic [WIDTH-1:0] red_and;
    logic [WIDTH-1:0] red_or;
    logic [WIDTH-1:0] red_xor;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;
    logic             q_valid_q;

    for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_chan
        ff_chain #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_chain (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .load (ch_en[i]),
            .d    (d[i*WIDTH +: WIDTH]),
            .q    (ch_q[i*WIDTH +: WIDTH])
        );
    end

    // Valid travels in lock-step with data, independent of ch_en.
    ff_chain #(
        .WIDTH (1),
        .DEPTH (DEPTH)
    ) u_valid (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .load (1'b1),
        .d    (in_valid),
        .q    (v_last)
    );

    always_comb begin
        red_and = '1;
        red_or  = '0;
        red_xor = '0;
        q_d     = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            red_and = red_and & ch_q[i*WIDTH +: WIDTH];
            red_or  = red_or  | ch_q[i*WIDTH +: WIDTH];
            red_xor = red_xor ^ ch_q[i*WIDTH +: WIDTH];
        end
        case (mode)
            MODE_AND:   q_d = red_and;
            MODE_OR:    q_d = red_or;
            MODE_XOR:   q_d = red_xor;
            MODE_PASS0: q_d = ch_q[WIDTH-1:0];
            default:    q_d = ch_q[WIDTH-1:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q       <= '0;
            q_valid_q <= 1'b0;
        end else if (en) begin
            q_q       <= q_d;
            q_valid_q <= v_last;
        end
    end

    assign q       = q_q;
    assign q_valid = q_valid_q;

endmodule

// File: tb/tb_multi_ff_reduce.sv
// Self-checking bench: vector table plus hand sequences, with a scoreboard
// queue matching every q_valid result against the value pushed at injection.
module tb_multi_ff_reduce;

    localparam int unsigned CH = 2;
    localparam int unsigned W  = 4;
    localparam int unsigned DP = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [CH-1:0]   ch_en;
    logic [CH*W-1:0] d;
    logic            in_valid;
    logic [1:0]      mode;
    logic [CH*W-1:0] ch_q;
    logic [W-1:0]    q;
    logic            q_valid;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic [W-1:0] sb[$];

    multi_ff_reduce #(
        .CHANNELS (CH),
        .WIDTH    (W),
        .DEPTH    (DP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .ch_en    (ch_en),
        .d        (d),
        .in_valid (in_valid),
        .mode     (mode),
        .ch_q     (ch_q),
        .q        (q),
        .q_valid  (q_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        logic [3:0] d0;
        logic [3:0] d1;
        logic [1:0] ch_en;
        logic [7:0] exp_chq;
        logic [3:0] exp_q;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock; any freshly advanced q_valid is matched against the scoreboard.
    task automatic tick();
        logic en_s;
        logic [W-1:0] exp;
        en_s = en;
        @(posedge clk);
        #1;
        if (en_s && q_valid) begin
            pulses++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_q_valid: got q=%0h with no pending result at %0t", q, $time);
            end else begin
                exp = sb.pop_front();
                check("sb_q", 32'(q), 32'(exp));
            end
        end
    endtask

    task automatic check_zero(input string name);
        check({name, "_chq"}, 32'(ch_q), 32'h0);
        check({name, "_q"}, 32'(q), 32'h0);
        check({name, "_qv"}, 32'(q_valid), 32'h0);
    endtask

    task automatic settle_zero();
        d = '0; ch_en = 2'b11; in_valid = 1'b0; en = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        vecs[0] = '{2'b00, 4'hC, 4'hA, 2'b11, 8'hAC, 4'h8};
        vecs[1] = '{2'b01, 4'hC, 4'hA, 2'b11, 8'hAC, 4'hE};
        vecs[2] = '{2'b10, 4'hC, 4'hA, 2'b11, 8'hAC, 4'h6};
        vecs[3] = '{2'b11, 4'hC, 4'hA, 2'b11, 8'hAC, 4'hC};
        vecs[4] = '{2'b01, 4'h3, 4'h5, 2'b01, 8'hA3, 4'hB};
        vecs[5] = '{2'b10, 4'hF, 4'h0, 2'b10, 8'h03, 4'h3};
        vecs[6] = '{2'b00, 4'h7, 4'hE, 2'b11, 8'hE7, 4'h6};

        // Reset with all-ones data and valid asserted.
        rst = 1'b1; en = 1'b1; ch_en = 2'b11; d = 8'hFF; in_valid = 1'b1; mode = 2'b00;
        tick(); check_zero("rst_c1");
        tick(); check_zero("rst_c2");
        rst = 1'b0; in_valid = 1'b0;
        check_zero("rst_rel");
        tick(); check_zero("rst_post");

        settle_zero();

        // Table: one isolated valid per vector, mode held until it emerges.
        for (int i = 0; i < 7; i++) begin
            mode = vecs[i].mode;
            d = {vecs[i].d1, vecs[i].d0};
            ch_en = vecs[i].ch_en;
            in_valid = 1'b1;
            sb.push_back(vecs[i].exp_q);
            tick();
            in_valid = 1'b0; ch_en = 2'b00;
            tick();
            check($sformatf("vec%0d_chq", i), 32'(ch_q), 32'(vecs[i].exp_chq));
            tick();
            check($sformatf("vec%0d_qv", i), 32'(q_valid), 32'h1);
            check($sformatf("vec%0d_q", i), 32'(q), 32'(vecs[i].exp_q));
            tick();
            check($sformatf("vec%0d_single", i), 32'(q_valid), 32'h0);
        end

        // Back-to-back valids in OR mode.
        mode = 2'b01; ch_en = 2'b11; in_valid = 1'b1;
        d = {4'h2, 4'h1}; sb.push_back(4'h3); tick();
        d = {4'h8, 4'h4}; sb.push_back(4'hC); tick();
        d = {4'h5, 4'h5}; sb.push_back(4'h5); tick();
        in_valid = 1'b0;
        repeat (4) tick();
        check("b2b_drained", 32'(sb.size()), 32'h0);

        // Stall: three en=0 cycles after T+1 delay the result by three cycles.
        settle_zero();
        mode = 2'b00; d = {4'hA, 4'hC}; in_valid = 1'b1;
        sb.push_back(4'h8);
        tick();
        in_valid = 1'b0;
        tick();
        check("stall_t1_chq", 32'(ch_q), 32'hAC);
        en = 1'b0; d = 8'hFF; in_valid = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick();
            check($sformatf("stall%0d_chq", s), 32'(ch_q), 32'hAC);
            check($sformatf("stall%0d_q", s), 32'(q), 32'h0);
            check($sformatf("stall%0d_qv", s), 32'(q_valid), 32'h0);
        end
        en = 1'b1; in_valid = 1'b0; d = 8'h00;
        tick();
        check("stall_qv", 32'(q_valid), 32'h1);
        check("stall_q", 32'(q), 32'h8);
        tick();
        check("stall_single", 32'(q_valid), 32'h0);

        // Reset mid-flight discards the in-flight valid.
        settle_zero();
        mode = 2'b01; d = {4'h5, 4'h5}; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("mid_chq", 32'(ch_q), 32'h55);
        rst = 1'b1;
        tick();
        check_zero("mid_rst");
        rst = 1'b0; d = 8'h00;
        for (int s = 0; s < 4; s++) begin
            tick();
            check($sformatf("mid_post%0d_qv", s), 32'(q_valid), 32'h0);
        end

        check("sb_empty", 32'(sb.size()), 32'h0);
        check("pulse_count", 32'(pulses), 32'd11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
